// File: rtl/seg_scroll.sv
// Scrolling digit-pattern register for a multi-digit display: a prescaler paces
// rotate/shift steps, with an optional hold period after each full revolution.
module seg_scroll #(
    parameter int                          DIGITS      = 6,
    parameter int                          CODE_W      = 4,
    parameter int                          STEP_CYCLES = 50_000_000,
    parameter int                          DWELL_STEPS = 0,
    parameter logic [DIGITS*CODE_W-1:0]    INIT        = 24'h012345,
    parameter logic [CODE_W-1:0]           FILL        = 4'hF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       dir,
    input  logic                       mode,
    input  logic                       load,
    input  logic [DIGITS*CODE_W-1:0]   load_data,
    output logic [DIGITS*CODE_W-1:0]   data_out,
    output logic                       step_pulse,
    output logic                       cycle_done,
    output logic                       dwelling
);

    localparam int W   = DIGITS * CODE_W;
    localparam int PW  = $clog2(STEP_CYCLES);
    localparam int SW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DWW = (DWELL_STEPS > 1) ? $clog2(DWELL_STEPS) : 1;

    localparam logic [PW-1:0]  PRESC_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0]  STEP_LAST  = SW'(DIGITS - 1);
    localparam logic [DWW-1:0] DWELL_LAST = DWW'((DWELL_STEPS > 0) ? DWELL_STEPS - 1 : 0);

    typedef enum logic {
        RUN   = 1'b0,
        DWELL = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SW-1:0]   step_cnt_q, step_cnt_d;
    logic [DWW-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [W-1:0]    data_q, data_d;
    logic            step_pulse_q, step_pulse_d;
    logic            cycle_done_q, cycle_done_d;
    logic            dwelling_q, dwelling_d;

    logic            tick;
    logic [CODE_W-1:0] in_right, in_left;
    logic [W-1:0]    step_pat;

    // Code entering the vacated end: the digit falling off the other end, or FILL.
    always_comb begin
        in_right = mode ? FILL : data_q[CODE_W-1:0];
        in_left  = mode ? FILL : data_q[W-1:W-CODE_W];
        step_pat = dir ? {data_q[W-CODE_W-1:0], in_left}
                       : {in_right, data_q[W-1:CODE_W]};
    end

    always_comb begin
        tick         = en && (presc_q == PRESC_LAST);
        state_d      = state_q;
        presc_d      = presc_q;
        step_cnt_d   = step_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        data_d       = data_q;
        step_pulse_d = 1'b0;
        cycle_done_d = 1'b0;

        if (load) begin
            // A coincident tick is dropped: the prescaler restarts from zero.
            data_d      = load_data;
            presc_d     = '0;
            step_cnt_d  = '0;
            dwell_cnt_d = '0;
            state_d     = RUN;
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                case (state_q)
                    RUN: begin
                        data_d       = step_pat;
                        step_pulse_d = 1'b1;
                        if (step_cnt_q == STEP_LAST) begin
                            step_cnt_d   = '0;
                            cycle_done_d = 1'b1;
                            if (DWELL_STEPS > 0) begin
                                state_d = DWELL;
                            end
                        end else begin
                            step_cnt_d = step_cnt_q + 1'b1;
                        end
                    end
                    DWELL: begin
                        if (dwell_cnt_q == DWELL_LAST) begin
                            dwell_cnt_d = '0;
                            state_d     = RUN;
                        end else begin
                            dwell_cnt_d = dwell_cnt_q + 1'b1;
                        end
                    end
                    default: state_d = RUN;
                endcase
            end
        end

        dwelling_d = (state_d == DWELL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            presc_q      <= '0;
            step_cnt_q   <= '0;
            dwell_cnt_q  <= '0;
            data_q       <= INIT;
            step_pulse_q <= 1'b0;
            cycle_done_q <= 1'b0;
            dwelling_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            step_cnt_q   <= step_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            data_q       <= data_d;
            step_pulse_q <= step_pulse_d;
            cycle_done_q <= cycle_done_d;
            dwelling_q   <= dwelling_d;
        end
    end

    assign data_out   = data_q;
    assign step_pulse = step_pulse_q;
    assign cycle_done = cycle_done_q;
    assign dwelling   = dwelling_q;

endmodule

// File: tb/tb_seg_scroll.sv
// Bench for seg_scroll: two instances (no dwell / two-step dwell) share stimulus
// and are compared every cycle against a digit-array reference model.
module tb_seg_scroll;

    localparam int DIGITS = 6;
    localparam int CODE_W = 4;
    localparam int W      = DIGITS * CODE_W;
    localparam int SC     = 4;
    localparam logic [W-1:0]      INIT_V = 24'h012345;
    localparam logic [CODE_W-1:0] FILL_V = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
    logic [W-1:0] ld_in = '0;

    logic [W-1:0] data0, data1;
    logic sp0, cd0, dw0, sp1, cd1, dw1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_scroll #(.DIGITS(DIGITS), .CODE_W(CODE_W), .STEP_CYCLES(SC), .DWELL_STEPS(0),
                 .INIT(INIT_V), .FILL(FILL_V)) d0 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_data(ld_in), .data_out(data0), .step_pulse(sp0), .cycle_done(cd0),
        .dwelling(dw0));

    seg_scroll #(.DIGITS(DIGITS), .CODE_W(CODE_W), .STEP_CYCLES(SC), .DWELL_STEPS(2),
                 .INIT(INIT_V), .FILL(FILL_V)) d1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_data(ld_in), .data_out(data1), .step_pulse(sp1), .cycle_done(cd1),
        .dwelling(dw1));

    // Reference model: digits as an array, progress as plain integer counts.
    logic [CODE_W-1:0] m_dg [2][DIGITS];
    int m_en_cyc [2];
    int m_steps [2];
    int m_dwell_left [2];
    logic m_step [2];
    logic m_done [2];

    function automatic int dwell_of(int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic [W-1:0] m_pack(int k);
        logic [W-1:0] p;
        for (int i = 0; i < DIGITS; i++) p[i*CODE_W +: CODE_W] = m_dg[k][i];
        return p;
    endfunction

    task automatic m_set(int k, logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) m_dg[k][i] = v[i*CODE_W +: CODE_W];
        m_en_cyc[k] = 0;
        m_steps[k] = 0;
        m_dwell_left[k] = 0;
        m_step[k] = 1'b0;
        m_done[k] = 1'b0;
    endtask

    task automatic m_edge(int k);
        logic [CODE_W-1:0] old [DIGITS];
        m_step[k] = 1'b0;
        m_done[k] = 1'b0;
        if (rst) m_set(k, INIT_V);
        else if (load) m_set(k, ld_in);
        else if (en) begin
            m_en_cyc[k]++;
            if (m_en_cyc[k] % SC == 0) begin
                if (m_dwell_left[k] > 0) m_dwell_left[k]--;
                else begin
                    old = m_dg[k];
                    if (dir == 1'b0) begin
                        for (int i = 0; i < DIGITS - 1; i++) m_dg[k][i] = old[i+1];
                        m_dg[k][DIGITS-1] = mode ? FILL_V : old[0];
                    end else begin
                        for (int i = 1; i < DIGITS; i++) m_dg[k][i] = old[i-1];
                        m_dg[k][0] = mode ? FILL_V : old[DIGITS-1];
                    end
                    m_step[k] = 1'b1;
                    m_steps[k]++;
                    if (m_steps[k] == DIGITS) begin
                        m_steps[k] = 0;
                        m_done[k] = 1'b1;
                        m_dwell_left[k] = dwell_of(k);
                    end
                end
            end
        end
    endtask

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("d0.data_out", data0, m_pack(0));
        check("d0.step_pulse", W'(sp0), W'(m_step[0]));
        check("d0.cycle_done", W'(cd0), W'(m_done[0]));
        check("d0.dwelling", W'(dw0), W'(m_dwell_left[0] > 0));
        check("d1.data_out", data1, m_pack(1));
        check("d1.step_pulse", W'(sp1), W'(m_step[1]));
        check("d1.cycle_done", W'(cd1), W'(m_done[1]));
        check("d1.dwelling", W'(dw1), W'(m_dwell_left[1] > 0));
    endtask

    task automatic cycle();
        @(posedge clk);
        m_edge(0);
        m_edge(1);
        #1;
        compare_all();
    endtask

    task automatic do_load(logic [W-1:0] v);
        load = 1'b1;
        ld_in = v;
        cycle();
        load = 1'b0;
    endtask

    // Three non-tick cycles with scrambled dir/mode, then the tick with the wanted ones.
    task automatic step_and_check(logic [W-1:0] exp, logic exp_done, logic d, logic m);
        en = 1'b1;
        for (int i = 0; i < SC - 1; i++) begin
            dir = 1'($urandom);
            mode = 1'($urandom);
            cycle();
            check("no_step_between_ticks", W'(sp0), '0);
        end
        dir = d;
        mode = m;
        cycle();
        check("step.data", data0, exp);
        check("step.pulse", W'(sp0), W'(1));
        check("step.done", W'(cd0), W'(exp_done));
    endtask

    typedef struct {
        logic en, dir, mode, load;
        logic [W-1:0] ld;
        logic [W-1:0] exp_data;
        logic exp_step, exp_done;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h012345, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h012345, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h012345, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h501234, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 24'h0,      24'h501234, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h0,      24'h501234, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h0,      24'h501234, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      24'h450123, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h012345, 24'h012345, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h0,      24'h012345, 1'b0, 1'b0};

        m_set(0, INIT_V);
        m_set(1, INIT_V);

        // Reset state
        cycle();
        cycle();
        check("reset.data", data0, 24'h012345);
        check("reset.step", W'(sp0), '0);
        check("reset.dwell", W'(dw1), '0);
        rst = 1'b0;

        // Basic right rotation from reset, plus load with en=0
        for (int i = 0; i < 10; i++) begin
            en = tbl[i].en;
            dir = tbl[i].dir;
            mode = tbl[i].mode;
            load = tbl[i].load;
            ld_in = tbl[i].ld;
            cycle();
            check($sformatf("tbl[%0d].data", i), data0, tbl[i].exp_data);
            check($sformatf("tbl[%0d].step", i), W'(sp0), W'(tbl[i].exp_step));
            check($sformatf("tbl[%0d].done", i), W'(cd0), W'(tbl[i].exp_done));
        end
        load = 1'b0;

        // Left rotation full revolution; cycle_done only on the sixth step
        en = 1'b1;
        do_load(24'h012345);
        step_and_check(24'h123450, 1'b0, 1'b1, 1'b0);
        step_and_check(24'h234501, 1'b0, 1'b1, 1'b0);
        step_and_check(24'h345012, 1'b0, 1'b1, 1'b0);
        step_and_check(24'h450123, 1'b0, 1'b1, 1'b0);
        step_and_check(24'h501234, 1'b0, 1'b1, 1'b0);
        step_and_check(24'h012345, 1'b1, 1'b1, 1'b0);

        // Dwell instance holds for two step periods, then resumes
        check("dwell.enter", W'(dw1), W'(1));
        dir = 1'b1;
        mode = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (c <= 7) begin
                check("dwell.high", W'(dw1), W'(1));
                check("dwell.hold", data1, 24'h012345);
            end
            if (c == 8) begin
                check("dwell.exit", W'(dw1), '0);
                check("dwell.no_step", W'(sp1), '0);
            end
            if (c == 12) begin
                check("dwell.resume", data1, 24'h123450);
                check("dwell.resume_step", W'(sp1), W'(1));
            end
        end

        // Shift right with FILL
        do_load(24'h012345);
        step_and_check(24'hF01234, 1'b0, 1'b0, 1'b1);
        step_and_check(24'hFF0123, 1'b0, 1'b0, 1'b1);
        step_and_check(24'hFFF012, 1'b0, 1'b0, 1'b1);
        step_and_check(24'hFFFF01, 1'b0, 1'b0, 1'b1);
        step_and_check(24'hFFFFF0, 1'b0, 1'b0, 1'b1);
        step_and_check(24'hFFFFFF, 1'b1, 1'b0, 1'b1);

        // Load on the tick cycle wins; then freeze with en=0
        do_load(24'h012345);
        dir = 1'b0;
        mode = 1'b1;
        repeat (SC - 1) cycle();
        do_load(24'hABCDEF);
        check("load_tick.data", data0, 24'hABCDEF);
        check("load_tick.step", W'(sp0), '0);
        check("load_tick.done", W'(cd0), '0);
        step_and_check(24'hFABCDE, 1'b0, 1'b0, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dir = 1'($urandom);
            mode = 1'($urandom);
            cycle();
            check("freeze.data", data0, 24'hFABCDE);
            check("freeze.step", W'(sp0), '0);
        end

        // Asynchronous reset mid-step, then first tick counted from first enabled edge
        en = 1'b1;
        do_load(24'h13579B);
        repeat (SC + 2) cycle();
        #2;
        rst = 1'b1;
        #1;
        m_set(0, INIT_V);
        m_set(1, INIT_V);
        compare_all();
        check("async_rst.data", data0, 24'h012345);
        en = 1'b0;
        cycle();
        rst = 1'b0;
        repeat (3) cycle();
        step_and_check(24'h501234, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            dir = 1'($urandom);
            mode = 1'($urandom);
            load = ($urandom_range(0, 59) == 0);
            ld_in = W'($urandom);
            rst = ($urandom_range(0, 799) == 0);
            cycle();
        end
        rst = 1'b0;
        load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scroll.md
SEG_SCROLL -- requirements
Module: seg_scroll

Interface
REQ-001 SHALL have parameter DIGITS, default 6: number of display digits.
REQ-002 SHALL have parameter CODE_W, default 4: bits per digit code.
REQ-003 SHALL have parameter STEP_CYCLES, default 50_000_000: clk cycles per scroll step (1 s at 50 MHz); legal range is >= 2.
REQ-004 SHALL have parameter DWELL_STEPS, default 0: step periods to hold after each full revolution; 0 means no hold.
REQ-005 SHALL have parameter INIT, default 24'h012345 (width DIGITS*CODE_W): reset pattern.
REQ-006 SHALL have parameter FILL, default 4'hF (width CODE_W): code inserted in shift mode.
REQ-007 clk  input  1  system clock, 50 MHz.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 en  input  1  1 = prescaler and scrolling advance; 0 = freeze.
REQ-010 dir  input  1  0 = scroll right (toward LSB digit); 1 = scroll left.
REQ-011 mode  input  1  0 = rotate; 1 = shift with FILL inserted.
REQ-012 load  input  1  single-cycle strobe to load a new pattern.
REQ-013 load_data  input  DIGITS*CODE_W  pattern captured on load.
REQ-014 data_out  output  DIGITS*CODE_W  current digit pattern; digit 0 is in bits [CODE_W-1:0].
REQ-015 step_pulse  output  1  1-cycle pulse on every pattern step.
REQ-016 cycle_done  output  1  1-cycle pulse on the step that completes DIGITS steps.
REQ-017 dwelling  output  1  high while in DWELL state.

Function
REQ-018 Prescaler SHALL count 0..STEP_CYCLES-1 while en=1, wrapping to 0; tick = (count==STEP_CYCLES-1) && en.
REQ-019 With en=0, prescaler, step counter, state and data_out SHALL hold their values.
REQ-020 FSM states SHALL be RUN and DWELL; reset state is RUN.
REQ-021 In RUN, each tick SHALL update data_out on the same clk edge, i.e. the value is visible the cycle after the tick; step_pulse SHALL be asserted in that same cycle.
REQ-022 Right step: rotate gives {d[CODE_W-1:0], d[W-1:CODE_W]}; shift gives {FILL, d[W-1:CODE_W]}.
REQ-023 Left step: rotate gives {d[W-CODE_W-1:0], d[W-1:W-CODE_W]}; shift gives {d[W-CODE_W-1:0], FILL}.
REQ-024 dir and mode SHALL be sampled only on the tick cycle; changing them between ticks SHALL have no effect.
REQ-025 Step counter SHALL count 0..DIGITS-1; the step taken at count DIGITS-1 SHALL wrap the counter to 0 and pulse cycle_done together with step_pulse.
REQ-026 After cycle_done, if DWELL_STEPS>0, FSM SHALL enter DWELL; otherwise it SHALL stay in RUN.
REQ-027 In DWELL, ticks SHALL only count; data_out SHALL hold and step_pulse SHALL stay 0. After DWELL_STEPS ticks, FSM SHALL return to RUN, and the next tick SHALL step.
REQ-028 load SHALL have priority over all other activity, regardless of en. On load: data_out=load_data, prescaler=0, step counter=0, state=RUN, and no step_pulse or cycle_done in that cycle.
REQ-029 If load coincides with a tick, load SHALL win and the tick SHALL be discarded.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While rst=1: data_out=INIT, prescaler=0, step counter=0, dwell counter=0, state=RUN, step_pulse=0, cycle_done=0, dwelling=0.
REQ-032 Asserting rst mid-step or mid-dwell SHALL abort immediately, with no residual pulse after release.
REQ-033 The first tick after release SHALL occur STEP_CYCLES cycles after the first en=1 edge.

Verification (STEP_CYCLES=4, DIGITS=6, CODE_W=4, INIT=24'h012345, FILL=4'hF)
REQ-034 Reset release, en=1, dir=0, mode=0 -> data_out 012345, then 501234 after 4 cycles, then 450123; step_pulse every 4th cycle.
REQ-035 dir=1, mode=0, 6 ticks -> 123450, 234501, ..., back to 012345; cycle_done only on the 6th step.
REQ-036 mode=1, dir=0 from 012345 -> F01234, FF0123, ..., FFFFFF after 6 steps.
REQ-037 DWELL_STEPS=2 -> after cycle_done, dwelling=1 for 8 cycles with data_out static, then stepping resumes.
REQ-038 load with load_data=24'hABCDEF on a tick cycle -> data_out=ABCDEF, no step_pulse, next step 4 cycles later gives FABCDE; en=0 for 10 cycles -> no change.
